mem_bus_decoder: RTL and testbench

Parametrised memory-bus decoder and response multiplexer for the picorv32 native bus (valid/ready/addr/wdata/wstrb/rdata). It replaces the hand-wired OR-reduction of per-peripheral ready/rdata in the top level with one registered block. The block decodes NUM_SLAVES address windows, routes each transaction to exactly one slave, and returns a defined error word on unmapped or hung accesses. Error state is sticky so firmware can read it after a fault. The block sits between the core (or the clock-crossing output) and its peripherals.

---
 rtl/mem_bus_decoder.sv | 180 ++++++++++++++++++
 tb/tb_mem_bus_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_decoder.sv
// Purpose : address-window decoder and response mux for the picorv32 native bus;
//           routes each request to one slave and answers unmapped or hung accesses
//           with ERR_RDATA. Errors are sticky until err_clear_i.
// Latency : mapped access 2 cycles minimum (+1 per slave wait cycle), unmapped 1 cycle,
//           timeout TIMEOUT_CYCLES+1 cycles after slv_valid_o rises.
// Backpressure: one transaction outstanding; new requests are ignored while busy and
//           during the mem_ready_o pulse.
// Ports   : clk/resetn (async active-low); mem_* master side; slv_* shared slave
//           side with one-hot slv_valid_o; err_clear_i, decode_err_o, timeout_err_o,
//           err_addr_o sticky error status; busy_o high outside IDLE.
// Option  : define BUS_DECODER_TIMEOUT_EN to build the WAIT timeout counter;
//           otherwise WAIT holds until the selected slave answers.
module mem_bus_decoder #(
   parameter int unsigned              NUM_SLAVES     = 8,
   parameter logic [NUM_SLAVES*32-1:0] BASE_ADDRS     = '0,
   parameter logic [NUM_SLAVES*32-1:0] ADDR_MASKS     = {NUM_SLAVES{32'hFF000000}},
   parameter int unsigned              TIMEOUT_CYCLES = 255,
   parameter logic [31:0]              ERR_RDATA      = 32'hDEADBEEF
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       mem_valid_i,
   input  logic [31:0]                mem_addr_i,
   input  logic [31:0]                mem_wdata_i,
   input  logic [3:0]                 mem_wstrb_i,
   output logic                       mem_ready_o,
   output logic [31:0]                mem_rdata_o,
   output logic [NUM_SLAVES-1:0]      slv_valid_o,
   output logic [31:0]                slv_addr_o,
   output logic [31:0]                slv_wdata_o,
   output logic [3:0]                 slv_wstrb_o,
   input  logic [NUM_SLAVES-1:0]      slv_ready_i,
   input  logic [NUM_SLAVES*32-1:0]   slv_rdata_i,
   input  logic                       err_clear_i,
   output logic                       decode_err_o,
   output logic                       timeout_err_o,
   output logic [31:0]                err_addr_o,
   output logic                       busy_o
);

   localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
      $error("mem_bus_decoder: NUM_SLAVES must be 1..16");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("mem_bus_decoder: TIMEOUT_CYCLES must be 1..65535");
   end

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                 state;
   logic [SEL_W-1:0]       sel_q;
   logic [31:0]            resp_q;

   logic                   hit;
   logic [SEL_W-1:0]       hit_idx;
   logic [NUM_SLAVES-1:0]  hit_onehot;
   logic                   sel_ready;
   logic [31:0]            sel_rdata;

   // Scan from the top so the lowest matching slot is the last assignment.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
         if ((mem_addr_i & ADDR_MASKS[i*32 +: 32]) ==
             (BASE_ADDRS[i*32 +: 32] & ADDR_MASKS[i*32 +: 32])) begin
            hit     = 1'b1;
            hit_idx = SEL_W'(i);
         end
      end
   end

   assign hit_onehot = NUM_SLAVES'(1) << hit_idx;

   // Only the latched slot is listened to; other slaves' ready is ignored.
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
         if (sel_q == SEL_W'(i)) begin
            sel_ready = slv_ready_i[i];
            sel_rdata = slv_rdata_i[i*32 +: 32];
         end
      end
   end

`ifdef BUS_DECODER_TIMEOUT_EN
   logic [15:0] wait_cnt;
   logic        timeout_hit;
   assign timeout_hit = (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_err_o = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         sel_q        <= '0;
         resp_q       <= '0;
         mem_ready_o  <= 1'b0;
         mem_rdata_o  <= '0;
         slv_valid_o  <= '0;
         slv_addr_o   <= '0;
         slv_wdata_o  <= '0;
         slv_wstrb_o  <= '0;
         decode_err_o <= 1'b0;
         err_addr_o   <= '0;
         busy_o       <= 1'b0;
`ifdef BUS_DECODER_TIMEOUT_EN
         wait_cnt      <= '0;
         timeout_err_o <= 1'b0;
`endif
      end else begin
         mem_ready_o <= 1'b0;
         mem_rdata_o <= '0;

         // Clear first so an error raised in this same cycle overrides it.
         if (err_clear_i) begin
            decode_err_o <= 1'b0;
            err_addr_o   <= '0;
`ifdef BUS_DECODER_TIMEOUT_EN
            timeout_err_o <= 1'b0;
`endif
         end

         case (state)
            IDLE: begin
               // mem_valid_i is still high during our ready pulse; do not re-accept it.
               if (mem_valid_i && !mem_ready_o) begin
                  busy_o <= 1'b1;
                  if (hit) begin
                     slv_addr_o  <= mem_addr_i;
                     slv_wdata_o <= mem_wdata_i;
                     slv_wstrb_o <= mem_wstrb_i;
                     sel_q       <= hit_idx;
                     slv_valid_o <= hit_onehot;
                     state       <= WAIT;
                  end else begin
                     decode_err_o <= 1'b1;
                     err_addr_o   <= mem_addr_i;
                     resp_q       <= ERR_RDATA;
                     state        <= RESP;
                  end
               end
            end
            WAIT: begin
               if (sel_ready) begin
                  resp_q      <= (slv_wstrb_o == 4'd0) ? sel_rdata : 32'd0;
                  slv_valid_o <= '0;
                  state       <= RESP;
               end
`ifdef BUS_DECODER_TIMEOUT_EN
               else if (timeout_hit) begin
                  slv_valid_o   <= '0;
                  timeout_err_o <= 1'b1;
                  err_addr_o    <= slv_addr_o;
                  resp_q        <= ERR_RDATA;
                  state         <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
`endif
            end
            RESP: begin
               mem_ready_o <= 1'b1;
               mem_rdata_o <= resp_q;
               busy_o      <= 1'b0;
               state       <= IDLE;
`ifdef BUS_DECODER_TIMEOUT_EN
               wait_cnt    <= '0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Purpose : self-checking bench for mem_bus_decoder (4 slots, overlapping windows,
//           TIMEOUT_CYCLES = 16) against a transaction-level reference model.
// Ports   : none; drives all DUT ports, samples on the falling edge.
module tb_mem_bus_decoder;

   localparam int NS = 4;
   localparam int TO = 16;
   localparam logic [NS*32-1:0] BASES = {32'h10000000, 32'h12000000, 32'h20000000, 32'h10000000};
   localparam logic [NS*32-1:0] MASKS = {32'hF0000000, 32'hFF000000, 32'hFF000000, 32'hFF000000};
`ifdef BUS_DECODER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic              clk, resetn;
   logic              mem_valid_i;
   logic [31:0]       mem_addr_i, mem_wdata_i;
   logic [3:0]        mem_wstrb_i;
   logic              mem_ready_o;
   logic [31:0]       mem_rdata_o;
   logic [NS-1:0]     slv_valid_o;
   logic [31:0]       slv_addr_o, slv_wdata_o;
   logic [3:0]        slv_wstrb_o;
   logic [NS-1:0]     slv_ready_i;
   logic [NS*32-1:0]  slv_rdata_i;
   logic              err_clear_i;
   logic              decode_err_o, timeout_err_o;
   logic [31:0]       err_addr_o;
   logic              busy_o;

   mem_bus_decoder #(
      .NUM_SLAVES(NS), .BASE_ADDRS(BASES), .ADDR_MASKS(MASKS),
      .TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEADBEEF)
   ) dut (
      .clk(clk), .resetn(resetn),
      .mem_valid_i(mem_valid_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
      .mem_wstrb_i(mem_wstrb_i), .mem_ready_o(mem_ready_o), .mem_rdata_o(mem_rdata_o),
      .slv_valid_o(slv_valid_o), .slv_addr_o(slv_addr_o), .slv_wdata_o(slv_wdata_o),
      .slv_wstrb_o(slv_wstrb_o), .slv_ready_i(slv_ready_i), .slv_rdata_i(slv_rdata_i),
      .err_clear_i(err_clear_i), .decode_err_o(decode_err_o), .timeout_err_o(timeout_err_o),
      .err_addr_o(err_addr_o), .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference address map, written out independently of the packed parameters.
   logic [31:0] m_base [NS] = '{32'h10000000, 32'h20000000, 32'h12000000, 32'h10000000};
   logic [31:0] m_mask [NS] = '{32'hFF000000, 32'hFF000000, 32'hFF000000, 32'hF0000000};

   // Sticky status as the model expects it.
   bit          m_dec, m_to;
   logic [31:0] m_eaddr;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int ref_slot(input logic [31:0] a);
      for (int i = 0; i < NS; i++)
         if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
      return -1;
   endfunction

   // One complete master transaction. waits = slave cycles with ready low before it
   // answers; stray = raise ready on every non-selected slave while waiting;
   // clr = pulse err_clear_i in the request cycle.
   task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                      input int waits, input bit stray, input bit clr, input logic [31:0] sdata);
      int            slot, pulse_n, hi_last;
      bit            to_case;
      logic [31:0]   exp_rd;
      logic [NS-1:0] exp_v;
      slot    = ref_slot(addr);
      to_case = (slot >= 0) && TO_EN && (waits >= TO);
      exp_rd  = 32'hDEADBEEF;
      if (slot < 0) begin
         pulse_n = 2; hi_last = 0;
      end else if (to_case) begin
         pulse_n = TO + 2; hi_last = TO;
      end else begin
         pulse_n = waits + 3; hi_last = waits + 1;
      end
      if (clr) begin m_dec = 0; m_to = 0; m_eaddr = '0; end
      if (slot < 0) begin m_dec = 1; m_eaddr = addr; end
      if (to_case)  begin m_to = 1;  m_eaddr = addr; end

      mem_valid_i = 1'b1; mem_addr_i = addr; mem_wdata_i = wdata;
      mem_wstrb_i = wstrb; err_clear_i = clr;
      for (int n = 1; n <= pulse_n; n++) begin
         @(posedge clk); @(negedge clk);
         err_clear_i = 1'b0;
         slv_ready_i = '0;
         exp_v = (slot >= 0 && n <= hi_last) ? (NS'(1) << slot) : '0;
         check("slv_valid", 32'(slv_valid_o), 32'(exp_v));
         check("mem_ready", 32'(mem_ready_o), 32'(n == pulse_n));
         check("busy", 32'(busy_o), 32'(n < pulse_n));
         if (n != pulse_n) check("rdata_idle", mem_rdata_o, 32'd0);
         if (n == 1 && slot >= 0) begin
            check("slv_addr", slv_addr_o, addr);
            check("slv_wdata", slv_wdata_o, wdata);
            check("slv_wstrb", 32'(slv_wstrb_o), 32'(wstrb));
         end
         if (n == pulse_n) begin
            check("mem_rdata", mem_rdata_o, exp_rd);
            check("decode_err", 32'(decode_err_o), 32'(m_dec));
            check("timeout_err", 32'(timeout_err_o), 32'(m_to));
            check("err_addr", err_addr_o, m_eaddr);
         end
         // Slave side for the coming cycle.
         for (int i = 0; i < NS; i++) slv_rdata_i[i*32 +: 32] = $urandom;
         if (slot >= 0 && n <= hi_last) begin
            if (stray)
               for (int i = 0; i < NS; i++) if (i != slot) slv_ready_i[i] = 1'b1;
            if (n == waits + 1) begin
               slv_ready_i[slot] = 1'b1;
               slv_rdata_i[slot*32 +: 32] = sdata;
               exp_rd = (wstrb != 4'd0) ? 32'd0 : sdata;
            end
         end
      end
      // Master still holds valid through the pulse cycle; it must not be re-accepted.
      @(posedge clk); @(negedge clk);
      slv_ready_i = '0;
      check("post_ready", 32'(mem_ready_o), 32'd0);
      check("post_busy", 32'(busy_o), 32'd0);
      check("post_valid", 32'(slv_valid_o), 32'd0);
      mem_valid_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          r, w;
      logic [31:0] a;
      resetn = 1'b0; mem_valid_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0;
      mem_wstrb_i = '0; slv_ready_i = '0; slv_rdata_i = '0; err_clear_i = 1'b0;
      m_dec = 0; m_to = 0; m_eaddr = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(mem_ready_o), 32'd0);
      check("rst_rdata", mem_rdata_o, 32'd0);
      check("rst_valid", 32'(slv_valid_o), 32'd0);
      check("rst_addr", slv_addr_o, 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_flags", 32'({decode_err_o, timeout_err_o}), 32'd0);
      check("rst_eaddr", err_addr_o, 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // Mapped read, slot 2, three wait cycles.
      txn(32'h12000004, 32'h0, 4'h0, 3, 1'b0, 1'b0, 32'hA5A50001);
      // Unmapped read.
      txn(32'h30000000, 32'h0, 4'h0, 0, 1'b0, 1'b0, 32'h0);
      // Clear after an error.
      err_clear_i = 1'b1;
      @(posedge clk); @(negedge clk);
      err_clear_i = 1'b0;
      m_dec = 0; m_to = 0; m_eaddr = '0;
      check("clr_dec", 32'(decode_err_o), 32'd0);
      check("clr_eaddr", err_addr_o, 32'd0);
      // Hung slave, then ready arriving on the last allowed cycle after a clear.
      txn(32'h20000010, 32'h0, 4'h0, TO, 1'b0, 1'b0, 32'h11112222);
      txn(32'h20000014, 32'h0, 4'h0, TO - 1, 1'b0, 1'b1, 32'h33334444);
      // Overlapping windows with ready from every other slave during WAIT.
      txn(32'h10000000, 32'h0, 4'h0, 2, 1'b1, 1'b0, 32'h55556666);
      // Back-to-back write then read to different slots.
      txn(32'h20000040, 32'hCAFEF00D, 4'hF, 1, 1'b0, 1'b0, 32'h77778888);
      txn(32'h1A000008, 32'h0, 4'h0, 0, 1'b0, 1'b0, 32'h9999AAAA);
      // New decode error in the same cycle as a clear.
      txn(32'h3F000004, 32'h0, 4'h0, 0, 1'b0, 1'b0, 32'h0);
      txn(32'h40000008, 32'h0, 4'h0, 0, 1'b0, 1'b1, 32'h0);

      for (int k = 0; k < 80; k++) begin
         r = $urandom_range(0, 5);
         case (r)
            0: a = {8'h10, 24'($urandom)};
            1: a = {8'h20, 24'($urandom)};
            2: a = {8'h12, 24'($urandom)};
            3: a = {4'h1, 4'($urandom_range(3, 15)), 24'($urandom)};
            4: a = {4'($urandom_range(3, 15)), 28'($urandom)};
            default: a = {8'($urandom_range(8'h21, 8'h2F)), 24'($urandom)};
         endcase
         w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 4);
         txn(a, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
             w, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), $urandom);
      end

      // Asynchronous reset while a slave is pending.
      mem_valid_i = 1'b1; mem_addr_i = 32'h20000000; mem_wstrb_i = 4'h0;
      @(posedge clk); @(negedge clk);
      mem_valid_i = 1'b0;
      check("pre_rst_valid", 32'(slv_valid_o), 32'b0010);
      @(posedge clk); #2;
      resetn = 1'b0;
      #1;
      check("arst_valid", 32'(slv_valid_o), 32'd0);
      check("arst_busy", 32'(busy_o), 32'd0);
      check("arst_flags", 32'({decode_err_o, timeout_err_o}), 32'd0);
      check("arst_eaddr", err_addr_o, 32'd0);
      m_dec = 0; m_to = 0; m_eaddr = '0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      txn(32'h12000100, 32'h0, 4'h0, 0, 1'b0, 1'b0, 32'hBEEF0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
